conv_pe_wrapper: RTL and testbench

//  KxK processing-element array for one convolution window: one K-pixel row per cycle in,
//  one unsigned dot product per kernel row out.
//  Row r = sum_k dataIn[k]*W[r][k]; input rows skew 2 cycles per PE row (systolic wavefront).

---
 rtl/conv_pe_pkg.sv | 23 ++
 rtl/conv_pe_wrapper_pe_row.sv | 69 ++++++
 rtl/conv_pe_wrapper.sv | 101 ++++++++++
 tb/tb_conv_pe_wrapper.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pe_pkg.sv
// Shared types and width helpers for the convolution PE array.
// Every width in the array is derived here so the wrapper and the rows agree.
package conv_pe_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } load_state_e;

    function automatic int product_width(input int data_w, input int weight_w);
        return data_w + weight_w;
    endfunction

    function automatic int sum_width(input int product_w, input int kernel_size);
        return product_w + kernel_size;
    endfunction

    function automatic int count_width(input int kernel_size);
        return (kernel_size > 1) ? $clog2(kernel_size) : 1;
    endfunction

endpackage

// File: rtl/conv_pe_wrapper_pe_row.sv
// One kernel row: skews the pixel row by DELAY cycles, then registers K products
// and their zero-extended sum (two stages).
module pe_row
    import conv_pe_pkg::*;
#(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int DELAY        = 0,
    localparam int PRODUCT_WIDTH = product_width(DATA_WIDTH, WEIGHT_WIDTH),
    localparam int SUM_WIDTH     = sum_width(PRODUCT_WIDTH, KERNEL_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]    data_in,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]  weights,
    output logic [SUM_WIDTH-1:0]                 row_sum
);
    localparam int K = KERNEL_SIZE;

    logic [DATA_WIDTH*K-1:0]    row_data;
    logic [PRODUCT_WIDTH-1:0]   prod_q [K];
    logic [SUM_WIDTH-1:0]       sum_next;
    logic [SUM_WIDTH-1:0]       sum_q;

    // Row r sees the pixel row 2r cycles late, forming the systolic wavefront.
    generate
        if (DELAY == 0) begin : g_direct
            assign row_data = data_in;
        end else begin : g_skew
            logic [DATA_WIDTH*K-1:0] skew_q [DELAY];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < DELAY; i++) skew_q[i] <= '0;
                end else begin
                    skew_q[0] <= data_in;
                    for (int i = 1; i < DELAY; i++) skew_q[i] <= skew_q[i-1];
                end
            end

            assign row_data = skew_q[DELAY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < K; k++) prod_q[k] <= '0;
        end else begin
            for (int k = 0; k < K; k++) begin
                prod_q[k] <= PRODUCT_WIDTH'(row_data[k*DATA_WIDTH +: DATA_WIDTH])
                           * PRODUCT_WIDTH'(weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            end
        end
    end

    always_comb begin
        sum_next = '0;
        for (int k = 0; k < K; k++) sum_next = sum_next + SUM_WIDTH'(prod_q[k]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sum_q <= '0;
        else       sum_q <= sum_next;
    end

    assign row_sum = sum_q;

endmodule

// File: rtl/conv_pe_wrapper.sv
// KxK PE array for one convolution window: loads weights row by row after reset,
// then streams pixel rows and presents one gated dot product per kernel row.
module conv_pe_wrapper
    import conv_pe_pkg::*;
#(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    localparam int PRODUCT_WIDTH = product_width(DATA_WIDTH, WEIGHT_WIDTH),
    localparam int SUM_WIDTH     = sum_width(PRODUCT_WIDTH, KERNEL_SIZE)
) (
    input  logic                                            clk,
    input  logic                                            rstn,
    input  logic                                            en,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]               dataIn,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] weightsIn,
    output logic [SUM_WIDTH*KERNEL_SIZE-1:0]                dataOut,
    output logic                                            dataOut_done,
    output logic                                            ready
);
    localparam int K     = KERNEL_SIZE;
    localparam int ROW_W = WEIGHT_WIDTH * K;
    localparam int CNT_W = count_width(K);
    localparam int VLEN  = 2 * K;

    load_state_e          state;
    load_state_e          next_state;
    logic [CNT_W-1:0]     load_row;
    logic                 load_en;
    logic [ROW_W-1:0]     weight_q [K];
    logic [VLEN-1:0]      valid_q;
    logic                 accept;
    logic [SUM_WIDTH-1:0] row_sum [K];

    // Handshake: a pixel row is taken on a rising edge only when en && ready;
    // there is no backpressure once ready, the pipeline never stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_LOAD;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_LOAD:  if (load_row == CNT_W'(K - 1)) next_state = S_ARM;
            S_ARM:   next_state = S_RUN;
            S_RUN:   next_state = S_RUN;
            default: next_state = S_LOAD;
        endcase
    end

    always_comb begin
        load_en = (state == S_LOAD);
        ready   = (state == S_RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        load_row <= '0;
        else if (load_en) load_row <= load_row + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < K; r++) weight_q[r] <= '0;
        end else if (load_en) begin
            for (int r = 0; r < K; r++) begin
                if (load_row == CNT_W'(r)) weight_q[r] <= weightsIn[r*ROW_W +: ROW_W];
            end
        end
    end

    assign accept = en && ready;

    // valid_q[i] marks a sample accepted i+1 edges ago; row r's sum is live at bit 2r+1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) valid_q <= '0;
        else       valid_q <= {valid_q[VLEN-2:0], accept};
    end

    generate
        for (genvar r = 0; r < K; r++) begin : g_row
            pe_row #(
                .KERNEL_SIZE  (K),
                .DATA_WIDTH   (DATA_WIDTH),
                .WEIGHT_WIDTH (WEIGHT_WIDTH),
                .DELAY        (2 * r)
            ) u_row (
                .clk     (clk),
                .rstn    (rstn),
                .data_in (dataIn),
                .weights (weight_q[r]),
                .row_sum (row_sum[r])
            );

            assign dataOut[r*SUM_WIDTH +: SUM_WIDTH] = valid_q[2*r+1] ? row_sum[r] : '0;
        end
    endgenerate

    assign dataOut_done = |valid_q;

endmodule

// File: tb/tb_conv_pe_wrapper.sv
// Bench for conv_pe_wrapper: random streams against a history-based dot-product model,
// plus hand-computed literal checks for the reset, ramp, identity and max-value cases.
module tb_conv_pe_wrapper;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int SW = DW + WW + K;

    typedef logic [DW*K-1:0] data_t;
    typedef struct {
        bit    acc;
        data_t data;
    } slot_t;

    logic              clk;
    logic              rstn;
    logic              en;
    data_t             data_in;
    logic [WW*K*K-1:0] weights;
    logic [SW*K-1:0]   data_out;
    logic              done;
    logic              ready;

    int checks;
    int failures;
    bit check_on;

    // Model state: accepted-sample history (index 0 = last edge) and latched weights.
    slot_t hist[$];
    int    rel_edges;
    bit    m_ready;
    int    w_m[K][K];

    conv_pe_wrapper #(
        .KERNEL_SIZE  (K),
        .DATA_WIDTH   (DW),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .dataIn       (data_in),
        .weightsIn    (weights),
        .dataOut      (data_out),
        .dataOut_done (done),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint row_of(input int r);
        logic [SW-1:0] v;
        v = data_out[r*SW +: SW];
        return longint'(v);
    endfunction

    task automatic set_w(input int r, input int c, input int val);
        weights[(r*K+c)*WW +: WW] = 8'(val);
    endtask

    // mode 0: W[r][*]=r+1, 1: identity, 2: all 255, 3: random
    task automatic set_all_weights(input int mode);
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                case (mode)
                    0:       set_w(r, c, r + 1);
                    1:       set_w(r, c, (r == c) ? 1 : 0);
                    2:       set_w(r, c, 255);
                    default: set_w(r, c, int'($urandom_range(0, 255)));
                endcase
            end
        end
    endtask

    function automatic data_t pack3(input int a, input int b, input int c);
        data_t d;
        d = '0;
        d[0*DW +: DW] = 8'(a);
        d[1*DW +: DW] = 8'(b);
        d[2*DW +: DW] = 8'(c);
        return d;
    endfunction

    // Reference model: advance history on every rising edge.
    always @(posedge clk) begin
        slot_t s;
        if (!rstn) begin
            hist.delete();
            rel_edges = 0;
            m_ready   = 1'b0;
        end else begin
            s.acc  = en && m_ready;
            s.data = data_in;
            hist.push_front(s);
            if (hist.size() > 2*K) void'(hist.pop_back());
            rel_edges++;
            if (rel_edges == K + 1) begin
                m_ready = 1'b1;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        w_m[r][c] = int'(weights[(r*K+c)*WW +: WW]);
            end
        end
    end

    function automatic longint exp_row(input int r);
        longint acc_sum;
        data_t  d;
        acc_sum = 0;
        if (!rstn) return 0;
        if (hist.size() <= 1 + 2*r) return 0;
        if (!hist[1+2*r].acc) return 0;
        d = hist[1+2*r].data;
        for (int k = 0; k < K; k++)
            acc_sum += longint'(d[k*DW +: DW]) * longint'(w_m[r][k]);
        return acc_sum;
    endfunction

    function automatic bit exp_done();
        if (!rstn) return 1'b0;
        for (int j = 0; j < hist.size(); j++) if (hist[j].acc) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        #2;
        if (check_on) begin
            for (int r = 0; r < K; r++) check("model_row", row_of(r), exp_row(r));
            check("model_done", longint'(done), longint'(exp_done()));
            check("model_ready", longint'(ready), longint'(rstn && m_ready));
        end
    end

    task automatic do_reset(input int wmode);
        @(negedge clk);
        rstn = 1'b0;
        en   = 1'b0;
        set_all_weights(wmode);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (K + 1) @(negedge clk);
    endtask

    initial begin
        int done_cnt;
        checks   = 0;
        failures = 0;
        check_on = 1'b0;
        rstn     = 1'b0;
        en       = 1'b0;
        data_in  = '0;
        weights  = '0;
        set_all_weights(0);

        // T1: reset state, then ready exactly K+1 edges after release; T5: en before ready.
        repeat (3) @(negedge clk);
        #2;
        for (int r = 0; r < K; r++) check("t1_reset_row", row_of(r), 0);
        check("t1_reset_done", longint'(done), 0);
        check("t1_reset_ready", longint'(ready), 0);
        check_on = 1'b1;
        rstn     = 1'b1;
        en       = 1'b1;
        data_in  = pack3(7, 8, 9);
        for (int c = 1; c <= K + 1; c++) begin
            @(negedge clk);
            #2;
            check("t1_ready_timing", longint'(ready), (c == K + 1) ? 1 : 0);
            check("t5_done_before_ready", longint'(done), 0);
        end
        en = 1'b0;
        repeat (2*K + 2) @(negedge clk);

        // T2: ramp inputs with W[r][*]=r+1.
        do_reset(0);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (t < 5) begin
                en      = 1'b1;
                data_in = pack3(t, t + 1, t + 2);
            end else begin
                en = 1'b0;
            end
            #2;
            if (t == 2)  check("t2_row0_test0", row_of(0), 3);
            if (t == 4)  check("t2_row1_test0", row_of(1), 6);
            if (t == 6)  check("t2_row2_test0", row_of(2), 9);
            if (t == 6)  check("t2_row0_test4", row_of(0), 15);
            if (t == 8)  check("t2_row1_test4", row_of(1), 30);
            if (t == 10) check("t2_row2_test4", row_of(2), 45);
        end

        // T3: single accept, identity weights.
        do_reset(1);
        done_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            en      = (t == 0);
            data_in = pack3(1, 2, 3);
            #2;
            if (t >= 1 && t <= 8 && done) done_cnt++;
            if (t == 2) check("t3_row0", row_of(0), 1);
            if (t == 4) check("t3_row1", row_of(1), 2);
            if (t == 6) check("t3_row2", row_of(2), 3);
        end
        check("t3_done_cycles", done_cnt, 2*K);

        // T4: full-scale operands must not wrap.
        do_reset(2);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            en      = (t == 0);
            data_in = pack3(255, 255, 255);
            #2;
            if (t == 2) check("t4_row0_max", row_of(0), 195075);
            if (t == 6) check("t4_row2_max", row_of(2), 195075);
        end

        // T6: random stream, late weight change, reset mid-stream.
        do_reset(3);
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 3) != 0);
            data_in = data_t'($urandom);
            if (t == 80) set_all_weights(3);
        end
        @(negedge clk);
        en   = 1'b1;
        rstn = 1'b0;
        #2;
        for (int r = 0; r < K; r++) check("t6_midreset_row", row_of(r), 0);
        check("t6_midreset_done", longint'(done), 0);
        check("t6_midreset_ready", longint'(ready), 0);
        repeat (2) @(negedge clk);
        set_all_weights(3);
        rstn = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 2) != 0);
            data_in = data_t'($urandom);
        end
        @(negedge clk);
        en = 1'b0;
        repeat (2*K + 4) @(negedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
